// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear FSM driving a gated seconds divider and a 00-59 BCD seconds count.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   key_ss     start/stop key (level, rising edge acts)
//   key_clr    clear key (level, rising edge acts)
//   key_lap    lap key (level, rising edge acts; only with STOPWATCH_LAP_EN)
//   s_ones     displayed seconds units 0-9
//   s_tens     displayed seconds tens 0-5
//   running    high while in RUN
//   tick       one-cycle pulse per elapsed second
//   wrap       one-cycle pulse when the count rolls 59 -> 00
//   lap_active high while the display is frozen
// Define STOPWATCH_LAP_EN to build the lap freeze; otherwise key_lap is ignored.
module stopwatch_ctrl #(
    parameter int TICK_CYCLES = 24000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_ss,
    input  logic       key_clr,
    input  logic       key_lap,
    output logic [3:0] s_ones,
    output logic [3:0] s_tens,
    output logic       running,
    output logic       tick,
    output logic       wrap,
    output logic       lap_active
);
    localparam int DW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t state, state_n;
    logic ss_d, clr_d, ss_e, clr_e, at_59;
    logic [DW-1:0] div;
    logic [3:0] ones, tens;

    assign ss_e  = key_ss & ~ss_d;
    assign clr_e = key_clr & ~clr_d;
    assign at_59 = (tens == 4'd5) && (ones == 4'd9);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_n;

    // clr only matters in PAUSE, where it beats a simultaneous ss
    always_comb
        state_n = (state == IDLE)  ? (ss_e ? RUN : IDLE) :
                  (state == RUN)   ? (ss_e ? PAUSE : RUN) :
                  clr_e ? IDLE : (ss_e ? RUN : PAUSE);

    always_comb running = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_d  <= 1'b0;
            clr_d <= 1'b0;
            div   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            ones  <= 4'd0;
            tens  <= 4'd0;
        end else begin
            ss_d  <= key_ss;
            clr_d <= key_clr;
            // a tick is still owed for the last RUN cycle even if the FSM leaves RUN on this edge
            tick  <= (state == RUN) && (div == DIV_MAX);
            wrap  <= tick && at_59 && (state_n != IDLE);
            if (state_n == IDLE) begin
                div  <= '0;
                ones <= 4'd0;
                tens <= 4'd0;
            end else begin
                if (state == RUN)
                    div <= (div == DIV_MAX) ? '0 : div + 1'b1;
                if (tick) begin
                    ones <= (ones == 4'd9) ? 4'd0 : ones + 4'd1;
                    tens <= (ones != 4'd9) ? tens : (tens == 4'd5) ? 4'd0 : tens + 4'd1;
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_d, lap_e, frozen;
    logic [3:0] snap_ones, snap_tens;

    assign lap_e = key_lap & ~lap_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_d     <= 1'b0;
            frozen    <= 1'b0;
            snap_ones <= 4'd0;
            snap_tens <= 4'd0;
        end else begin
            lap_d <= key_lap;
            if (state_n == IDLE || (lap_e && frozen)) begin
                frozen <= 1'b0;
            end else if (lap_e && state == RUN) begin
                frozen    <= 1'b1;
                snap_ones <= ones;
                snap_tens <= tens;
            end
        end
    end

    assign lap_active = frozen;
    assign s_ones     = frozen ? snap_ones : ones;
    assign s_tens     = frozen ? snap_tens : tens;
`else
    logic unused_lap;
    assign unused_lap = key_lap;
    assign lap_active = 1'b0;
    assign s_ones     = ones;
    assign s_tens     = tens;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table, corner sequences and random keys against a seconds-level model.
module tb_stopwatch_ctrl;
    localparam int T = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_ss = 1'b0, key_clr = 1'b0, key_lap = 1'b0;
    logic [3:0] s_ones, s_tens;
    logic running, tick, wrap, lap_active;

    stopwatch_ctrl #(.TICK_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .key_ss(key_ss), .key_clr(key_clr), .key_lap(key_lap),
        .s_ones(s_ones), .s_tens(s_tens), .running(running), .tick(tick),
        .wrap(wrap), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model: mode 0 idle / 1 run / 2 pause, elapsed RUN cycles, elapsed seconds mod 60
    int m_mode, m_run, m_secs, m_snap;
    bit m_tick, m_wrap, m_frozen, m_ssd, m_clrd, m_lapd;

    typedef struct {
        bit ss;
        bit clr;
        int n;
        bit run;
        bit tk;
        logic [3:0] tens;
        logic [3:0] ones;
    } vec_t;
    vec_t tbl[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_secs = 0; m_snap = 0;
        m_tick = 0; m_wrap = 0; m_frozen = 0;
        m_ssd = 0; m_clrd = 0; m_lapd = 0;
    endtask

    task automatic model_clock();
        bit ss_e, clr_e, lap_e, nt;
        int nm, ns;
        ss_e  = key_ss && !m_ssd;
        clr_e = key_clr && !m_clrd;
        lap_e = key_lap && !m_lapd;
        nm = (m_mode == 0) ? (ss_e ? 1 : 0) :
             (m_mode == 1) ? (ss_e ? 2 : 1) :
             (clr_e ? 0 : (ss_e ? 1 : 2));
        nt = (m_mode == 1) && ((m_run + 1) % T == 0);
        ns = m_tick ? (m_secs + 1) % 60 : m_secs;
        m_wrap = m_tick && (m_secs == 59) && (nm != 0);
        if (m_mode == 1) m_run++;
`ifdef STOPWATCH_LAP_EN
        if (nm == 0) m_frozen = 0;
        else if (lap_e && m_frozen) m_frozen = 0;
        else if (lap_e && m_mode == 1) begin
            m_frozen = 1;
            m_snap = m_secs;
        end
`else
        if (lap_e) m_frozen = 0;
`endif
        if (nm == 0) begin
            m_run = 0;
            ns = 0;
        end
        m_mode = nm; m_tick = nt; m_secs = ns;
        m_ssd = key_ss; m_clrd = key_clr; m_lapd = key_lap;
    endtask

    function automatic logic [11:0] exp_vec();
        int d;
        d = m_frozen ? m_snap : m_secs;
        return {4'(d / 10), 4'(d % 10), m_mode == 1, m_tick, m_wrap, m_frozen};
    endfunction

    task automatic step(input logic ss, input logic clr, input logic lap);
        key_ss = ss; key_clr = clr; key_lap = lap;
        @(posedge clk);
        model_clock();
        #1;
        check("cycle", {s_tens, s_ones, running, tick, wrap, lap_active}, exp_vec());
    endtask

    task automatic run_until(input string name, input logic [3:0] t, input logic [3:0] o, input int bound);
        bit found;
        found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            step(0, 0, 0);
            found = (s_tens == t) && (s_ones == o);
        end
        check(name, found, 1);
    endtask

    initial begin
        bit found;
        logic rs, rc, rl;
        tbl[0]  = '{0, 0,   2, 0, 0, 4'd0, 4'd0};
        tbl[1]  = '{1, 0,   1, 1, 0, 4'd0, 4'd0};
        tbl[2]  = '{0, 0,  10, 1, 1, 4'd0, 4'd0};
        tbl[3]  = '{0, 0,   1, 1, 0, 4'd0, 4'd1};
        tbl[4]  = '{0, 0,  10, 1, 0, 4'd0, 4'd2};
        tbl[5]  = '{0, 0,   3, 1, 0, 4'd0, 4'd2};
        tbl[6]  = '{1, 0,   1, 0, 0, 4'd0, 4'd2};
        tbl[7]  = '{0, 0,  50, 0, 0, 4'd0, 4'd2};
        tbl[8]  = '{1, 0,   1, 1, 0, 4'd0, 4'd2};
        tbl[9]  = '{0, 0,   4, 1, 0, 4'd0, 4'd2};
        tbl[10] = '{0, 0,   1, 1, 1, 4'd0, 4'd2};
        tbl[11] = '{0, 0,   1, 1, 0, 4'd0, 4'd3};
        tbl[12] = '{0, 1,   1, 1, 0, 4'd0, 4'd3};
        tbl[13] = '{0, 0,   1, 1, 0, 4'd0, 4'd3};
        tbl[14] = '{1, 0,   1, 0, 0, 4'd0, 4'd3};
        tbl[15] = '{0, 0,   2, 0, 0, 4'd0, 4'd3};
        tbl[16] = '{1, 1,   1, 0, 0, 4'd0, 4'd0};
        tbl[17] = '{0, 0,   1, 0, 0, 4'd0, 4'd0};
        tbl[18] = '{1, 0, 100, 1, 0, 4'd0, 4'd9};
        tbl[19] = '{0, 0,   1, 1, 1, 4'd0, 4'd9};
        tbl[20] = '{0, 0,   1, 1, 0, 4'd1, 4'd0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {s_tens, s_ones, running, tick, wrap, lap_active}, 12'h000);
        rst = 1'b1;

        for (int r = 0; r < 21; r++) begin
            for (int k = 0; k < tbl[r].n; k++) step(tbl[r].ss, tbl[r].clr, 1'b0);
            check($sformatf("row%0d", r), {running, tick, s_tens, s_ones},
                  {tbl[r].run, tbl[r].tk, tbl[r].tens, tbl[r].ones});
        end

        run_until("reach_59", 4'd5, 4'd9, 600);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 0);
            found = wrap;
        end
        check("wrap_seen", found, 1);
        check("wrap_disp", {s_tens, s_ones}, 8'h00);
        step(0, 0, 0);
        check("wrap_single", wrap, 0);

        run_until("reach_37", 4'd3, 4'd7, 500);
        rst = 1'b0;
        #1;
        model_reset();
        check("async_reset", {s_tens, s_ones, running, tick, wrap, lap_active}, 12'h000);
        @(posedge clk);
        #1;
        check("reset_hold", {s_tens, s_ones, running, tick, wrap, lap_active}, 12'h000);
        rst = 1'b1;

        rs = 0; rc = 0; rl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) rs = ~rs;
            if ($urandom_range(0, 59) == 0) rc = ~rc;
            if ($urandom_range(0, 49) == 0) rl = ~rl;
            step(rs, rc, rl);
        end

`ifdef STOPWATCH_LAP_EN
        rst = 1'b0;
        key_ss = 0; key_clr = 0; key_lap = 0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1, 0, 0);
        run_until("lap_reach_12", 4'd1, 4'd2, 200);
        step(0, 0, 1);
        check("lap_freeze", {lap_active, s_tens, s_ones}, {1'b1, 8'h12});
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(0, 0, 0);
            found = (m_secs == 17);
        end
        check("lap_live_17", found, 1);
        check("lap_hold", {lap_active, s_tens, s_ones}, {1'b1, 8'h12});
        step(0, 0, 1);
        check("lap_release", {lap_active, s_tens, s_ones}, {1'b0, 8'h17});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
